// File: rtl/datapath_ctrl.sv
// Instruction-sequencing controller for the 16-bit datapath: latches one instruction per handshake
// and steps the datapath through register read, execute and writeback. Optional ADDI: DATAPATH_CTRL_ADDI_EN.
module datapath_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   output logic        done,
   output logic        illegal,
   output logic        halted,
   output logic [2:0]  readnum1,
   output logic [2:0]  readnum2,
   output logic [2:0]  writenum,
   output logic        write,
   output logic [1:0]  vsel,
   output logic [1:0]  shift,
   output logic        asel,
   output logic        bsel,
   output logic [1:0]  ALUop,
   output logic        loadab,
   output logic        loadc,
   output logic        loads,
   output logic [15:0] sximm8,
   output logic [15:0] sximm5
);

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_GET_AB, S_EXEC, S_WRITE, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      K_MOVI, K_MOVR, K_ALU, K_CMP, K_HALT, K_ADDI, K_ILL
   } kind_t;

   state_t      state, state_next;
   kind_t       kind;
   logic [15:0] ir;

   logic [2:0] opc, rn, rd, rm;
   logic [1:0] op, sh;

   assign opc = ir[15:13];
   assign op  = ir[12:11];
   assign rn  = ir[10:8];
   assign rd  = ir[7:5];
   assign sh  = ir[4:3];
   assign rm  = ir[2:0];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         ir    <= '0;
      end else begin
         state <= state_next;
         if (state == S_IDLE && instr_valid)
            ir <= instr;
      end
   end

   always_comb begin
      kind = K_ILL;
      case (opc)
         3'b110: begin
            if (op == 2'b10)
               kind = K_MOVI;
            else if (op == 2'b00)
               kind = K_MOVR;
         end
         3'b101: begin
            if (op == 2'b01)
               kind = K_CMP;
            else
               kind = K_ALU;
         end
         3'b111: kind = K_HALT;
`ifdef DATAPATH_CTRL_ADDI_EN
         3'b100: begin
            if (op == 2'b00)
               kind = K_ADDI;
         end
`endif
         default: kind = K_ILL;
      endcase
   end

   // Datapath setup is a pure function of ir, so it stays stable for the whole instruction.
   assign readnum1 = rm;
   assign readnum2 = rn;
   assign writenum = (kind == K_MOVI) ? rn : rd;
   assign sximm8   = {{8{ir[7]}}, ir[7:0]};
   assign sximm5   = {{11{ir[4]}}, ir[4:0]};
   assign asel     = (kind == K_MOVR);

`ifdef DATAPATH_CTRL_ADDI_EN
   assign bsel  = (kind == K_ADDI);
   assign shift = (kind == K_ADDI) ? 2'b00 : sh;
`else
   assign bsel  = 1'b0;
   assign shift = sh;
`endif

   always_comb begin
      ALUop = 2'b00;
      if (kind == K_ALU || kind == K_CMP)
         ALUop = op;
   end

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      state_next  = state;
      instr_ready = 1'b0;
      done        = 1'b0;
      illegal     = 1'b0;
      halted      = 1'b0;
      write       = 1'b0;
      vsel        = 2'b00;
      loadab      = 1'b0;
      loadc       = 1'b0;
      loads       = 1'b0;
      case (state)
         S_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid)
               state_next = S_DECODE;
         end
         S_DECODE: begin
            case (kind)
               K_MOVI:  state_next = S_WRITE;
               K_HALT:  state_next = S_HALT;
               K_ILL: begin
                  done       = 1'b1;
                  illegal    = 1'b1;
                  state_next = S_IDLE;
               end
               default: state_next = S_GET_AB;
            endcase
         end
         S_GET_AB: begin
            loadab     = 1'b1;
            state_next = S_EXEC;
         end
         S_EXEC: begin
            if (kind == K_CMP) begin
               loads      = 1'b1;
               done       = 1'b1;
               state_next = S_IDLE;
            end else begin
               loadc      = 1'b1;
               state_next = S_WRITE;
            end
         end
         S_WRITE: begin
            write      = 1'b1;
            done       = 1'b1;
            vsel       = (kind == K_MOVI) ? 2'b01 : 2'b11;
            state_next = S_IDLE;
         end
         S_HALT: halted = 1'b1;
         default: state_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench for datapath_ctrl: a table of whole-instruction vectors plus hand-written
// sequences for handshake, halt, mid-instruction reset and the optional ADDI.
module tb_datapath_ctrl;

   logic        clk;
   logic        reset;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready, done, illegal, halted;
   logic [2:0]  readnum1, readnum2, writenum;
   logic        write;
   logic [1:0]  vsel, shift;
   logic        asel, bsel;
   logic [1:0]  ALUop;
   logic        loadab, loadc, loads;
   logic [15:0] sximm8, sximm5;

   datapath_ctrl dut (
      .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .done(done), .illegal(illegal), .halted(halted),
      .readnum1(readnum1), .readnum2(readnum2), .writenum(writenum), .write(write),
      .vsel(vsel), .shift(shift), .asel(asel), .bsel(bsel), .ALUop(ALUop),
      .loadab(loadab), .loadc(loadc), .loads(loads), .sximm8(sximm8), .sximm5(sximm5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] instr;
      int          cyc;
      logic        ill;
      logic        wr;
      logic [2:0]  wnum;
      logic [1:0]  vs;
      logic        ld;
      logic        chk_alu;
      logic [1:0]  alu;
   } vec_t;

   vec_t v[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      instr_valid = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   // Precondition: controller in IDLE. Returns in cycle 1 after the acceptance edge.
   task automatic accept(input logic [15:0] word);
      instr       = word;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
   endtask

   task automatic add_vec(input string name, input logic [15:0] word, input int cyc,
                          input logic ill, input logic wr, input logic [2:0] wnum,
                          input logic [1:0] vs, input logic ld, input logic chk_alu,
                          input logic [1:0] alu);
      vec_t e;
      e.name = name; e.instr = word; e.cyc = cyc; e.ill = ill; e.wr = wr;
      e.wnum = wnum; e.vs = vs; e.ld = ld; e.chk_alu = chk_alu; e.alu = alu;
      v.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         got, nw, nc, nab, nd;
      logic       d_ill, d_wr, d_ld, d_rdy;
      logic [2:0] d_wn;
      logic [1:0] d_vs, d_alu;

      reset = 1'b0; instr = '0; instr_valid = 1'b0;

      //        name      instr     cyc ill  wr   wnum  vsel   lds  chkA alu
      add_vec("movi_r3", 16'hD3FE, 2, 1'b0, 1'b1, 3'd3, 2'b01, 1'b0, 1'b0, 2'b00);
      add_vec("add",     16'hA148, 4, 1'b0, 1'b1, 3'd2, 2'b11, 1'b0, 1'b1, 2'b00);
      add_vec("cmp",     16'hAD06, 3, 1'b0, 1'b0, 3'd0, 2'b00, 1'b1, 1'b1, 2'b01);
      add_vec("and",     16'hB586, 4, 1'b0, 1'b1, 3'd4, 2'b11, 1'b0, 1'b1, 2'b10);
      add_vec("mvn",     16'hB8E1, 4, 1'b0, 1'b1, 3'd7, 2'b11, 1'b0, 1'b1, 2'b11);
      add_vec("movr",    16'hC022, 4, 1'b0, 1'b1, 3'd1, 2'b11, 1'b0, 1'b1, 2'b00);
      add_vec("ill_001", 16'h2000, 1, 1'b1, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0, 2'b00);
      add_vec("ill_110", 16'hC800, 1, 1'b1, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0, 2'b00);
      add_vec("ill_100", 16'h8800, 1, 1'b1, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0, 2'b00);
`ifdef DATAPATH_CTRL_ADDI_EN
      add_vec("addi",    16'h823D, 4, 1'b0, 1'b1, 3'd1, 2'b11, 1'b0, 1'b1, 2'b00);
`else
      add_vec("addi_ill",16'h823D, 1, 1'b1, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0, 2'b00);
`endif

      // Reset state.
      do_reset();
      check("rst_ready", instr_ready, 1);
      check("rst_outs", {done, illegal, halted, readnum1, readnum2, writenum, write, vsel,
                         shift, asel, bsel, ALUop, loadab, loadc, loads}, 0);
      check("rst_sximm", {sximm8, sximm5}, 0);

      // Table-driven whole-instruction vectors.
      foreach (v[i]) begin
         do_reset();
         accept(v[i].instr);
         got = -1; nw = 0; nc = 0; nab = 0;
         d_ill = 0; d_wr = 0; d_ld = 0; d_rdy = 1; d_wn = 0; d_vs = 0; d_alu = 0;
         for (int c = 1; c <= 8 && got < 0; c++) begin
            nw += int'(write); nc += int'(loadc); nab += int'(loadab);
            if (done) begin
               got = c; d_ill = illegal; d_wr = write; d_ld = loads; d_rdy = instr_ready;
               d_wn = writenum; d_vs = vsel; d_alu = ALUop;
            end else begin
               tick();
            end
         end
         check({v[i].name, "_done_cyc"}, got, v[i].cyc);
         check({v[i].name, "_illegal"}, d_ill, v[i].ill);
         check({v[i].name, "_write"}, d_wr, v[i].wr);
         check({v[i].name, "_vsel"}, d_vs, v[i].vs);
         check({v[i].name, "_loads"}, d_ld, v[i].ld);
         check({v[i].name, "_ready_in_done"}, d_rdy, 0);
         if (v[i].wr) check({v[i].name, "_writenum"}, d_wn, v[i].wnum);
         if (v[i].chk_alu) check({v[i].name, "_ALUop"}, d_alu, v[i].alu);
         check({v[i].name, "_n_write"}, nw, v[i].wr);
         check({v[i].name, "_n_loadc"}, nc, (v[i].cyc == 4));
         check({v[i].name, "_n_loadab"}, nab, (v[i].cyc >= 3));
         tick();
         check({v[i].name, "_ready_after"}, instr_ready, 1);
      end

      // MOV imm detail: immediates and return to ready.
      do_reset();
      accept(16'hD3FE);
      tick();
      check("movi_sximm8", sximm8, 16'hFFFE);
      check("movi_sximm5", sximm5, 16'hFFFE);
      tick();
      check("movi_ready_c3", instr_ready, 1);

      // ADD cycle by cycle, with a competing valid instruction while busy.
      do_reset();
      accept(16'hA148);
      check("add_c1_loadab", loadab, 0);
      instr = 16'hD3FE; instr_valid = 1'b1;
      tick();
      check("add_c2_get_ab", {loadab, readnum2, readnum1, shift}, {1'b1, 3'd1, 3'd0, 2'b01});
      tick();
      check("add_c3_exec", {loadc, loadab, ALUop, done}, {1'b1, 1'b0, 2'b00, 1'b0});
      tick();
      check("add_c4_write", {write, writenum, vsel, done}, {1'b1, 3'd2, 2'b11, 1'b1});
      instr_valid = 1'b0;
      tick();
      check("add_c5_ready", instr_ready, 1);

      // Valid held continuously: nothing accepted in the done cycle.
      do_reset();
      instr = 16'hD3FE; instr_valid = 1'b1;
      tick();
      check("hold_c1_ready", instr_ready, 0);
      tick();
      check("hold_c2_done", done, 1);
      tick();
      check("hold_c3_idle", {instr_ready, done}, {1'b1, 1'b0});
      tick();
      check("hold_c4_busy", {instr_ready, done}, {1'b0, 1'b0});
      tick();
      check("hold_c5_done", done, 1);
      instr_valid = 1'b0;
      tick();

      // Illegal then HALT; valid ignored while halted.
      do_reset();
      accept(16'h2000);
      check("ill_pulse", {illegal, done, write, loadab, loadc, loads, halted}, 7'b1100000);
      tick();
      accept(16'hE000);
      check("halt_c1", {halted, done}, {1'b0, 1'b0});
      tick();
      check("halt_c2", {halted, instr_ready}, {1'b1, 1'b0});
      instr = 16'hD3FE; instr_valid = 1'b1;
      nd = 0; nw = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         nd += int'(done); nw += int'(write);
      end
      check("halt_held", {halted, instr_ready}, {1'b1, 1'b0});
      check("halt_no_done", nd + nw, 0);
      do_reset();
      check("halt_cleared", {halted, instr_ready}, {1'b0, 1'b1});

      // Reset during EXEC of an ADD.
      accept(16'hA148);
      tick();
      tick();
      check("rstx_in_exec", loadc, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rstx_idle", {instr_ready, write, done, loadc}, {1'b1, 1'b0, 1'b0, 1'b0});
      nd = int'(done); nw = int'(write);
      for (int c = 0; c < 3; c++) begin
         tick();
         nd += int'(done); nw += int'(write);
      end
      check("rstx_no_strobes", nd + nw, 0);
      accept(16'hD3FE);
      tick();
      check("rstx_movi_done", {done, write, writenum, vsel}, {1'b1, 1'b1, 3'd3, 2'b01});
      tick();

      // ADDI detail.
      do_reset();
      accept(16'h823D);
`ifdef DATAPATH_CTRL_ADDI_EN
      check("addi_c1", {illegal, done}, {1'b0, 1'b0});
      tick();
      tick();
      check("addi_c3_exec", {bsel, sximm5, shift, ALUop, loadc},
            {1'b1, 16'hFFFD, 2'b00, 2'b00, 1'b1});
      tick();
      check("addi_c4_write", {write, writenum, done}, {1'b1, 3'd1, 1'b1});
`else
      check("addi_c1_illegal", {illegal, done, bsel}, {1'b1, 1'b1, 1'b0});
`endif
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
